// File: rtl/aer_addr_encoder_if.sv
// Grant/acknowledge, address stream and status signals of the AER address encoder.
// The master modport is the encoder side; slave is the arbiter/readout side.
interface aer_addr_encoder_if #(
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N),
  parameter int CNT_W  = 16
);
  logic [N-1:0]      ao;
  logic [N-1:0]      ack;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              multi_err;
  logic              err_clr;
  logic [CNT_W-1:0]  evt_cnt;

  modport master (
    input  ao, out_ready, err_clr,
    output ack, out_addr, out_valid, multi_err, evt_cnt
  );

  modport slave (
    output ao, out_ready, err_clr,
    input  ack, out_addr, out_valid, multi_err, evt_cnt
  );
endinterface

// File: rtl/aer_addr_encoder.sv
// Registered grant-to-address encoder with 4-phase acknowledge, fixed or
// round-robin priority, sticky multi-hot error flag and saturating event counter.
module aer_addr_encoder #(
  parameter int N       = 16,
  parameter int ADDR_W  = $clog2(N),
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  aer_addr_encoder_if.master bus
);

  localparam int unsigned NU = N;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state;
  logic [N-1:0]      r_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_sel;
  logic [ADDR_W-1:0] r_last_idx;
  logic              r_valid;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_sel;
  logic [N-1:0]      w_onehot;
  logic              w_multi;
  logic              w_capture;
  logic              w_release;

  // Scans run from the far end so the nearest candidate is written last and wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    w_sel = '0;
    if (RR_MODE == 0) begin
      for (int unsigned i = NU; i > 0; i--) begin
        idx = i - 1;
        if (bus.ao[idx[ADDR_W-1:0]]) w_sel = idx[ADDR_W-1:0];
      end
    end else begin
      for (int unsigned off = NU; off > 0; off--) begin
        idx = 32'(r_last_idx) + off;
        if (idx >= NU) idx = idx - NU;
        if (bus.ao[idx[ADDR_W-1:0]]) w_sel = idx[ADDR_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  assign w_multi   = |(bus.ao & (bus.ao - N'(1)));
  assign w_capture = (r_state == IDLE) && (|bus.ao) && (!r_valid || bus.out_ready);
  assign w_release = (r_state == HOLD) && !bus.ao[r_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_last_idx <= ADDR_W'(N - 1);
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (r_valid && bus.out_ready) r_valid <= 1'b0;
      if (bus.err_clr)              r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_addr     <= w_sel;
            r_valid    <= 1'b1;
            r_ack      <= w_onehot;
            r_sel      <= w_sel;
            r_last_idx <= w_sel;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_multi)     r_err <= 1'b1;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_release) begin
            r_ack   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.out_addr  = r_addr;
  assign bus.out_valid = r_valid;
  assign bus.multi_err = r_err;
  assign bus.evt_cnt   = r_cnt;

endmodule

// File: doc/aer_addr_encoder.md
Name: aer_addr_encoder

Overview:
- Parametrised, registered successor to the 16-input one-hot address encoder on the AER row/column periphery.
- Takes N arbiter grant lines and encodes the granted index into a binary address.
- Presents the address on a valid/ready stream to the readout FIFO.
- Returns a 4-phase acknowledge to the granted line, with selectable fixed or round-robin priority, multi-hot error detection and an event counter.

Parameters:
N, 16, number of grant lines; LSB is the bottom (ROW) or right-most (COL) pixel.
ADDR_W, $clog2(N), width of the output address.
RR_MODE, 0, 0 = lowest index wins; 1 = round-robin starting after the last served index.
CNT_W, 16, width of the saturating event counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ao  input  N  grant lines from arbiter, level-held until acknowledged
ack  output  N  one-hot acknowledge to the served line
out_addr  output  ADDR_W  encoded address
out_valid  output  1  out_addr is valid
out_ready  input  1  downstream accepts out_addr
multi_err  output  1  sticky flag: more than one ao bit seen at capture
err_clr  input  1  clears multi_err
evt_cnt  output  CNT_W  count of captured events, saturating

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - ack=0, out_addr=0, out_valid=0, multi_err=0, evt_cnt=0.
  - state=IDLE, last_idx=N-1, so the first round-robin search starts at index 0.
  - Reset mid-handshake drops ack immediately, even while ao is still high.
- FSM states are IDLE and HOLD.
- IDLE:
  - Capture occurs when ao!=0 and the output slot is free, i.e. (!out_valid || out_ready).
  - Selection with RR_MODE=0: lowest set index.
  - Selection with RR_MODE=1: the first set index scanning last_idx+1, last_idx+2, … with wrap modulo N.
  - On capture, at the next edge:
    - out_addr=sel, out_valid=1, ack=onehot(sel).
    - sel_r=sel, last_idx=sel.
    - evt_cnt increments, holding at 2^CNT_W-1.
    - multi_err is set if popcount(ao)>1.
    - state goes to HOLD.
  - If ao!=0 but the slot is not free, nothing changes and ack stays 0. Downstream back-pressure stalls the pixel.
- HOLD:
  - ack stays equal to onehot(sel_r).
  - When ao[sel_r]==0 at an edge: ack=0 and state goes to IDLE.
  - No capture happens in the same cycle as the release. The earliest next capture is the following edge.
  - Other ao bits rising during HOLD are ignored until IDLE.
- Latency: ao sampled at edge t; out_valid and ack are visible after edge t, i.e. 1 cycle.
- Output stream:
  - out_valid clears at an edge where out_valid && out_ready and no new capture occurs.
  - Capture and drain in the same cycle: out_valid stays 1 and out_addr takes the new value.
  - out_addr is stable while out_valid && !out_ready.
- multi_err:
  - Sticky until err_clr.
  - If err_clr and a new multi-hot capture occur in the same cycle, set wins.
- ao==0 in IDLE: no action. An all-zero input never produces an event; this differs from the legacy block, which held its output.
- Width: N may be any value ≥2. Indices ≥N never appear. The round-robin wrap uses N, not 2^ADDR_W.

Test Plan:
1. Fixed mode, N=16: ao=16'h0020 held. Expect out_addr=5, out_valid=1 and ack=16'h0020 one cycle later. Drop ao[5] → ack=0 next edge, evt_cnt=1, multi_err=0.
2. Multi-hot, fixed mode: ao=16'h8101. Expect out_addr=0 and multi_err=1. Pulse err_clr with ao=0 → multi_err=0.
3. Round-robin, N=16, ao=16'h8101 held, each line released and re-raised after its ack:
   - serves 0, 8, 15, then wraps to 0;
   - out_addr sequence is 0, 8, 15, 0.
4. Back-pressure: out_ready=0, first event on ao=16'h0004 captured (addr 2). Second request ao=16'h0010 after release gets no ack while out_valid=1. Raise out_ready → addr 2 drains, addr 4 is captured on the same edge and out_valid stays 1.
5. Reset mid-HOLD with ao[3] high → the next cycle has ack=0, out_valid=0, evt_cnt=0 and state IDLE. After rst falls, index 3 is recaptured.
6. Counter saturation with CNT_W=2: five events → evt_cnt reads 1, 2, 3, 3, 3. N=5 in round-robin mode with ao=5'b10001 → addresses 0, 4, 0, wrapping at 5.
